// File: rtl/logic_gate_unit.sv
// -----------------------------------------------------------------------------
// logic_gate_unit
//
// Purpose:
//   Registered, opcode-selected N-bit bitwise logic unit with a valid/ready
//   handshake and a single output register stage. An accumulate mode swaps
//   operand b for the last accepted result, so running AND/OR/XOR-style folds
//   can be built across beats.
//
// Optional feature:
//   LOGIC_GATE_UNIT_REDUCE_EN - when defined, adds the registered reduction
//   outputs red_and, red_or and red_xor of the result loaded into c.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept an input beat (combinational)
//   op         0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 PASS a
//   acc        1 = use the accumulator as operand b
//   acc_clr    synchronous accumulator clear, independent of the handshake
//   a, b       operands (b ignored when acc=1 or op is 6/7)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   c          registered result
//   red_and/red_or/red_xor  reductions of c (LOGIC_GATE_UNIT_REDUCE_EN only)
// -----------------------------------------------------------------------------
module logic_gate_unit #(
    parameter int           N        = 3,
    parameter logic [N-1:0] ACC_INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic         acc,
    input  logic         acc_clr,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    ,
    output logic         red_and,
    output logic         red_or,
    output logic         red_xor
`endif
);

    logic [N-1:0] acc_q;
    logic [N-1:0] operand_b;
    logic [N-1:0] result;
    logic         accept;

    // The output register may be refilled in the same cycle it drains.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        result    = '0;
        operand_b = acc ? acc_q : b;
        case (op)
            3'd0:    result = a & operand_b;
            3'd1:    result = a | operand_b;
            3'd2:    result = ~(a & operand_b);
            3'd3:    result = ~(a | operand_b);
            3'd4:    result = a ^ operand_b;
            3'd5:    result = ~(a ^ operand_b);
            3'd6:    result = ~a;
            default: result = a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            c         <= result;
        end else if (out_ready) begin
            // Drain: c keeps its last value, only the valid flag drops.
            out_valid <= 1'b0;
        end
    end

    // The clear takes priority over the load; an accept in the same cycle
    // has already consumed the old accumulator value through operand_b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= ACC_INIT;
        end else if (acc_clr) begin
            acc_q <= ACC_INIT;
        end else if (accept) begin
            acc_q <= result;
        end
    end

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_and <= 1'b0;
            red_or  <= 1'b0;
            red_xor <= 1'b0;
        end else if (accept) begin
            red_and <= &result;
            red_or  <= |result;
            red_xor <= ^result;
        end
    end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;

    localparam int           N        = 3;
    localparam logic [N-1:0] ACC_INIT = '0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic         acc;
    logic         acc_clr;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    logic         red_and;
    logic         red_or;
    logic         red_xor;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [N-1:0] m_c;
    logic         m_valid;
    logic [N-1:0] m_acc;
    logic         m_rand, m_ror, m_rxor;

    logic [N-1:0] sweep_exp [8];

    logic_gate_unit #(.N(N), .ACC_INIT(ACC_INIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc       (acc),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        ,
        .red_and   (red_and),
        .red_or    (red_or),
        .red_xor   (red_xor)
`endif
    );

    always #5 clk = ~clk;

    // Per-bit truth-table model: decide each output bit from how many of the
    // two input bits are set.
    function automatic logic [N-1:0] model_f(input int op_i, input logic [N-1:0] x,
                                             input logic [N-1:0] y);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int s;
            s = int'(x[i]) + int'(y[i]);
            case (op_i)
                0: r[i] = (s == 2);
                1: r[i] = (s >= 1);
                2: r[i] = (s != 2);
                3: r[i] = (s == 0);
                4: r[i] = (s == 1);
                5: r[i] = (s != 1);
                6: r[i] = (x[i] == 1'b0);
                default: r[i] = x[i];
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_c = '0; m_valid = 1'b0; m_acc = ACC_INIT;
        m_rand = 1'b0; m_ror = 1'b0; m_rxor = 1'b0;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        logic         take;
        logic [N-1:0] res;
        int           ones;
        take = in_valid && (!m_valid || out_ready);
        res  = model_f(int'(op), a, acc ? m_acc : b);
        @(posedge clk);
        #1;
        if (take) begin
            m_c = res; m_valid = 1'b1;
            ones = 0;
            for (int i = 0; i < N; i++) ones += int'(res[i]);
            m_rand = (ones == N); m_ror = (ones > 0); m_rxor = (ones % 2 == 1);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (acc_clr) m_acc = ACC_INIT;
        else if (take) m_acc = res;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; op = 3'd0; acc = 1'b0; acc_clr = 1'b0;
        a = 3'b111; b = 3'b111; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (c !== 3'b000) begin n_err++; $display("FAIL reset_c got=%b exp=000", c); end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        op = 3'd0; a = 3'b110; b = 3'b011; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++; if (c !== 3'b010) begin n_err++; $display("FAIL reset_first_c got=%b exp=010", c); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL reset_first_valid got=%b exp=1", out_valid); end
        tick();
    endtask

    task automatic test_opcode_sweep();
        out_ready = 1'b1; acc = 1'b0; a = 3'b101; b = 3'b011; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            op = 3'(k);
            tick();
            n_vec++; if (c !== sweep_exp[k]) begin n_err++; $display("FAIL sweep_op%0d_c got=%b exp=%b", k, c, sweep_exp[k]); end
            n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                n_err++; $display("FAIL sweep_op%0d_flow out_valid=%b in_ready=%b exp=1/1", k, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; acc = 1'b0; in_valid = 1'b1; op = 3'd1; a = 3'b101; b = 3'b011;
        tick();
        n_vec++; if (c !== 3'b111) begin n_err++; $display("FAIL bp_first_c got=%b exp=111", c); end
        out_ready = 1'b0; op = 3'd0; a = 3'b110; b = 3'b011;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", k, in_ready); end
            tick();
            n_vec++; if (c !== 3'b111 || out_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_hold cyc%0d c=%b out_valid=%b exp=111/1", k, c, out_valid);
            end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++; if (c !== 3'b010 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_release c=%b out_valid=%b exp=010/1", c, out_valid);
        end
        tick();
        n_vec++; if (out_valid !== 1'b0 || c !== 3'b010) begin
            n_err++; $display("FAIL bp_drain c=%b out_valid=%b exp=010/0", c, out_valid);
        end
    endtask

    task automatic test_accumulate();
        logic [N-1:0] seq_a [3];
        logic [N-1:0] seq_c [3];
        seq_a = '{3'b001, 3'b010, 3'b100};
        seq_c = '{3'b001, 3'b011, 3'b111};
        out_ready = 1'b1; in_valid = 1'b0; acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0; acc = 1'b1; op = 3'd1; in_valid = 1'b1; b = 3'b000;
        for (int k = 0; k < 3; k++) begin
            a = seq_a[k];
            tick();
            n_vec++; if (c !== seq_c[k]) begin n_err++; $display("FAIL acc_or step%0d got=%b exp=%b", k, c, seq_c[k]); end
        end
        acc_clr = 1'b1; a = 3'b000;
        tick();
        n_vec++; if (c !== 3'b111) begin n_err++; $display("FAIL acc_clr_same_cycle got=%b exp=111", c); end
        acc_clr = 1'b0;
        tick();
        n_vec++; if (c !== 3'b000) begin n_err++; $display("FAIL acc_after_clr got=%b exp=000", c); end
        in_valid = 1'b0; acc = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1; acc = 1'b1; op = 3'd1; a = 3'b111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || c !== 3'b111) begin
            n_err++; $display("FAIL arst_pre c=%b out_valid=%b exp=111/1", c, out_valid);
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (c !== 3'b000) begin n_err++; $display("FAIL arst_c got=%b exp=000", c); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1; acc = 1'b1; op = 3'd1; a = 3'b000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++; if (c !== ACC_INIT) begin n_err++; $display("FAIL arst_acc_init got=%b exp=%b", c, ACC_INIT); end
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op        = 3'($urandom_range(0, 7));
            acc       = 1'($urandom_range(0, 1));
            acc_clr   = ($urandom_range(0, 7) == 0);
            a         = N'($urandom);
            b         = N'($urandom);
            #1;
            n_vec++; if (in_ready !== (!m_valid || out_ready)) begin
                n_err++; $display("FAIL rand_in_ready cyc%0d got=%b exp=%b", k, in_ready, !m_valid || out_ready);
            end
            tick();
            n_vec++; if (out_valid !== m_valid || c !== m_c) begin
                n_err++; $display("FAIL rand_out cyc%0d c=%b out_valid=%b exp=%b/%b", k, c, out_valid, m_c, m_valid);
            end
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
            n_vec++; if (red_and !== m_rand || red_or !== m_ror || red_xor !== m_rxor) begin
                n_err++; $display("FAIL rand_red cyc%0d got=%b%b%b exp=%b%b%b", k, red_and, red_or, red_xor, m_rand, m_ror, m_rxor);
            end
`endif
        end
        acc_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
    endtask

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    task automatic test_reduce();
        out_ready = 1'b1; acc = 1'b0; op = 3'd4; a = 3'b110; b = 3'b011; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++; if (c !== 3'b101 || red_and !== 1'b0 || red_or !== 1'b1 || red_xor !== 1'b0) begin
            n_err++; $display("FAIL reduce c=%b red=%b%b%b exp=101 010", c, red_and, red_or, red_xor);
        end
        tick();
    endtask
`endif

    initial begin
        sweep_exp = '{3'b001, 3'b111, 3'b110, 3'b000, 3'b110, 3'b001, 3'b010, 3'b101};
        test_reset();
        test_opcode_sweep();
        test_backpressure();
        test_accumulate();
        test_async_reset();
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        test_reduce();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
